// File: rtl/axon_pkg.sv
// rtl/axon_pkg.sv - shared helpers for AXON datapath blocks
package axon_pkg;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// rtl/pipe_reg_stage.sv - one valid/data slot of the elastic pipeline register
module pipe_reg_stage #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready_in,
  output logic             vld,
  output logic [WIDTH-1:0] dat,
  output logic             rdy_out
);

  // An empty slot can always take a word, so bubbles collapse toward the output.
  assign rdy_out = !vld | dn_ready_in;

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld <= 1'b0;
      dat <= RST_VAL;
    end else if (rdy_out) begin
      vld <= up_valid;
      if (up_valid) dat <= up_data;
    end
  end

endmodule

// File: rtl/pipe_reg_elastic.sv
// rtl/pipe_reg_elastic.sv - DEPTH-stage elastic pipeline register with flush and occupancy
module pipe_reg_elastic
  import axon_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [cnt_w(DEPTH)-1:0]  count
);

  localparam int CW = cnt_w(DEPTH);

  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] up_valid;
  logic [WIDTH-1:0] dat     [DEPTH];
  logic [WIDTH-1:0] up_data [DEPTH];

  assign rdy[DEPTH] = out_ready;

  // Flush forces every slot to load an invalid word; data registers hold.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign up_valid[i] = in_valid & !flush;
      assign up_data[i]  = in_data;
    end else begin : g_body
      assign up_valid[i] = vld[i-1] & !flush;
      assign up_data[i]  = dat[i-1];
    end

    pipe_reg_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk         (clk),
      .rst         (rst),
      .up_valid    (up_valid[i]),
      .up_data     (up_data[i]),
      .dn_ready_in (rdy[i+1] | flush),
      .vld         (vld[i]),
      .dat         (dat[i]),
      .rdy_out     (rdy[i])
    );
  end

  assign in_ready  = rdy[0] & !flush & rst;
  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) count = count + CW'(vld[i]);
  end

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// tb/tb_pipe_reg_elastic.sv - randomized self-checking bench for pipe_reg_elastic
module tb_pipe_reg_elastic;

  localparam int         WIDTH = 8;
  localparam int         DEPTH = 3;
  localparam logic [7:0] RV    = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] count;

  int passed = 0;
  int total  = 0;

  // Reference: words in flight, oldest first, with the slot each occupies.
  logic [7:0] m_word[$];
  int         m_pos[$];
  logic [7:0] m_out[$];
  logic [7:0] d_out[$];
  logic [7:0] sent[$];

  always #5 clk = ~clk;

  pipe_reg_elastic #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(RV)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  function automatic bit m_in_ready();
    return rst && !flush && (m_word.size() < DEPTH || out_ready);
  endfunction

  function automatic bit m_out_valid();
    return m_word.size() > 0 && m_pos[0] == DEPTH - 1;
  endfunction

  function automatic logic [1:0] m_count();
    return 2'(m_word.size());
  endfunction

  task automatic tick();
    bit acc, emi;
    acc = in_valid && m_in_ready();
    emi = rst && out_ready && m_out_valid();
    if (emi) m_out.push_back(m_word[0]);
    if (rst && out_valid && out_ready) d_out.push_back(out_data);
    @(posedge clk);
    if (!rst) begin
      m_word.delete();
      m_pos.delete();
    end else begin
      // A word moves up when some slot ahead of it is free or the output drains.
      for (int k = 0; k < m_word.size(); k++)
        if (out_ready || k < DEPTH - 1 - m_pos[k]) m_pos[k]++;
      if (m_pos.size() > 0 && m_pos[0] == DEPTH) begin
        void'(m_pos.pop_front());
        void'(m_word.pop_front());
      end
      if (flush) begin
        m_word.delete();
        m_pos.delete();
      end
      if (acc) begin
        m_word.push_back(in_data);
        m_pos.push_back(0);
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + 1) tick();
    m_out.delete();
    d_out.delete();
    sent.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready_low got=%0b exp=0", in_ready); else passed++;
    tick();
    tick();
    rst = 1'b1; in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b exp=0", out_valid); else passed++;
    total++; if (count !== 2'd0) $display("FAIL reset_count got=%0d exp=0", count); else passed++;
    total++; if (out_data !== RV) $display("FAIL reset_out_data got=%h exp=%h", out_data, RV); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%0b exp=1", in_ready); else passed++;
  endtask

  task automatic test_stream();
    int first = -1;
    int bad = 0;
    drain();
    for (int c = 0; c < 22; c++) begin
      in_valid = (c < 16);
      in_data = 8'(c + 1);
      #1;
      if (c < 16) begin
        total++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready c=%0d got=%0b exp=1", c, in_ready); else passed++;
      end
      total++; if (out_valid !== m_out_valid()) $display("FAIL stream_out_valid c=%0d got=%0b exp=%0b", c, out_valid, m_out_valid()); else passed++;
      if (m_out_valid()) begin
        total++; if (out_data !== m_word[0]) $display("FAIL stream_out_data c=%0d got=%h exp=%h", c, out_data, m_word[0]); else passed++;
      end
      if (c == 5) begin
        total++; if (count !== 2'd3) $display("FAIL stream_count c=%0d got=%0d exp=3", c, count); else passed++;
      end
      if (out_valid === 1'b1 && first < 0) first = c;
      tick();
    end
    total++; if (first != 3) $display("FAIL stream_latency got=%0d exp=3", first); else passed++;
    for (int i = 0; i < d_out.size(); i++) if (d_out[i] !== 8'(i + 1)) bad++;
    total++; if (d_out.size() != 16 || bad != 0) $display("FAIL stream_order got_n=%0d bad=%0d exp_n=16 bad=0", d_out.size(), bad); else passed++;
  endtask

  task automatic test_backpressure();
    logic [7:0] abc[3];
    abc = '{8'hA1, 8'hB2, 8'hC3};
    drain();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = abc[i];
      tick();
    end
    in_data = 8'hDD;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if (count !== 2'd3) $display("FAIL bp_count c=%0d got=%0d exp=3", c, count); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready c=%0d got=%0b exp=0", c, in_ready); else passed++;
      total++; if (out_valid !== 1'b1 || out_data !== 8'hA1) $display("FAIL bp_hold c=%0d got=%0b/%h exp=1/a1", c, out_valid, out_data); else passed++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (out_valid !== 1'b1 || out_data !== abc[i]) $display("FAIL bp_release i=%0d got=%0b/%h exp=1/%h", i, out_valid, out_data, abc[i]); else passed++;
      tick();
    end
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL bp_empty got=%0b exp=0", out_valid); else passed++;
  endtask

  task automatic test_bubble();
    logic [7:0] w[4];
    w = '{8'h11, 8'h22, 8'h33, 8'h44};
    drain();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = w[i];
      #1;
      total++; if (in_ready !== (i < 3)) $display("FAIL bubble_in_ready i=%0d got=%0b exp=%0b", i, in_ready, (i < 3)); else passed++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (DEPTH + 1) tick();
    total++; if (d_out.size() != 3 || d_out[0] !== w[0] || d_out[1] !== w[1] || d_out[2] !== w[2])
      $display("FAIL bubble_order got_n=%0d exp_n=3", d_out.size()); else passed++;
  endtask

  task automatic test_full_accept_emit();
    int bad = 0;
    drain();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      sent.push_back(in_data);
      tick();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      #1;
      total++; if (count !== 2'd3) $display("FAIL full_count c=%0d got=%0d exp=3", c, count); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL full_in_ready c=%0d got=%0b exp=1", c, in_ready); else passed++;
      total++; if (out_valid !== 1'b1 || out_data !== sent[c]) $display("FAIL full_out c=%0d got=%0b/%h exp=1/%h", c, out_valid, out_data, sent[c]); else passed++;
      sent.push_back(in_data);
      tick();
    end
    in_valid = 1'b0;
    repeat (DEPTH + 1) tick();
    for (int i = 0; i < d_out.size() && i < sent.size(); i++) if (d_out[i] !== sent[i]) bad++;
    total++; if (d_out.size() != 103 || bad != 0) $display("FAIL full_order got_n=%0d bad=%0d exp_n=103 bad=0", d_out.size(), bad); else passed++;
  endtask

  task automatic test_flush();
    drain();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h61; tick();
    in_data = 8'h62; tick();
    in_data = 8'h63; flush = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got=%0b exp=0", in_ready); else passed++;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (count !== 2'd0) $display("FAIL flush_count got=%0d exp=0", count); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid got=%0b exp=0", out_valid); else passed++;
    out_ready = 1'b1;
    repeat (DEPTH + 1) tick();
    total++; if (d_out.size() != 0) $display("FAIL flush_discard got_n=%0d exp_n=0", d_out.size()); else passed++;
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    drain();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h30 + i);
      tick();
    end
    rst = 1'b0; in_data = 8'h99;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL midrst_in_ready got=%0b exp=0", in_ready); else passed++;
    tick();
    rst = 1'b1; in_valid = 1'b0;
    #1;
    total++; if (count !== 2'd0) $display("FAIL midrst_count got=%0d exp=0", count); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got=%0b exp=0", out_valid); else passed++;
    total++; if (out_data !== RV) $display("FAIL midrst_out_data got=%h exp=%h", out_data, RV); else passed++;
    d_out.delete(); m_out.delete();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h50 + i);
      tick();
    end
    in_valid = 1'b0;
    repeat (DEPTH + 1) tick();
    for (int i = 0; i < d_out.size(); i++) if (d_out[i] !== 8'(8'h50 + i)) bad++;
    total++; if (d_out.size() != 6 || bad != 0) $display("FAIL midrst_resume got_n=%0d bad=%0d exp_n=6 bad=0", d_out.size(), bad); else passed++;
  endtask

  task automatic test_random();
    int bad = 0;
    drain();
    for (int c = 0; c < 400; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      #1;
      total++; if (in_ready !== m_in_ready()) $display("FAIL rand_in_ready c=%0d got=%0b exp=%0b", c, in_ready, m_in_ready()); else passed++;
      total++; if (out_valid !== m_out_valid()) $display("FAIL rand_out_valid c=%0d got=%0b exp=%0b", c, out_valid, m_out_valid()); else passed++;
      total++; if (count !== m_count()) $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, count, m_count()); else passed++;
      if (m_out_valid()) begin
        total++; if (out_data !== m_word[0]) $display("FAIL rand_out_data c=%0d got=%h exp=%h", c, out_data, m_word[0]); else passed++;
      end
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (DEPTH + 1) tick();
    for (int i = 0; i < d_out.size() && i < m_out.size(); i++) if (d_out[i] !== m_out[i]) bad++;
    total++; if (d_out.size() != m_out.size() || bad != 0) $display("FAIL rand_order got_n=%0d bad=%0d exp_n=%0d bad=0", d_out.size(), bad, m_out.size()); else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_full_accept_emit();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
